// File: rtl/poly_wb_ctrl.sv
// poly_wb_ctrl: write-back sequencer downstream of the polynomial ALU.
// Captures destination address pairs at issue time in a small FIFO, writes
// the ALU results back to the dual-port coefficient RAM on poly_valid, counts
// retired operations, flags protocol errors and pulses wb_done per batch.
// Optional build macro POLY_WB_REG_OUT_EN: adds one register stage on all
// ram_* outputs (write latency 2) and delays wb_done by one cycle to match.
module poly_wb_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              poly_clk,
  input  logic              poly_rst_n,
  input  logic              wb_start,
  input  logic [8:0]        wb_count,
  input  logic [1:0]        wb_we_mask,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr0,
  input  logic [ADDR_W-1:0] issue_addr1,
  input  logic              poly_valid,
  input  logic [23:0]       poly_data_out0,
  input  logic [23:0]       poly_data_out1,
  output logic              ram_we0,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic [23:0]       ram_wdata0,
  output logic              ram_we1,
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [23:0]       ram_wdata1,
  output logic              wb_busy,
  output logic              wb_done,
  output logic              wb_err
);

  localparam int unsigned DATA_W = 24;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W  = PTR_W - 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e              state_q, state_nx;
  logic [CNT_W-1:0]    count_q, issued_q, retired_q;
  logic [1:0]          mask_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [2*ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [2*ADDR_W-1:0] head_c;
  logic                fifo_empty_c, fifo_full_c;
  logic                start_c, push_c, pop_c, err_set_c, done_c, abort_c;
  logic                err_q, busy_q, done_q;
  logic                we0_q, we1_q;
  logic [ADDR_W-1:0]   addr0_q, addr1_q;
  logic [DATA_W-1:0]   wdata0_q, wdata1_q;

  // FIFO status from extended pointers (MSB distinguishes wrap parity)
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head_c       = fifo_mem[rd_ptr_q[IDX_W-1:0]];

  // State register
  always_ff @(posedge poly_clk or negedge poly_rst_n) begin
    if (!poly_rst_n) state_q <= S_IDLE;
    else             state_q <= state_nx;
  end

  // Next state and per-cycle control decisions
  always_comb begin
    state_nx  = state_q;
    start_c   = 1'b0;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    err_set_c = 1'b0;
    done_c    = 1'b0;
    abort_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_start) begin
          start_c  = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        pop_c = poly_valid && !fifo_empty_c;
        if (poly_valid && fifo_empty_c) err_set_c = 1'b1;
        if (state_q == S_RUN) begin
          if (issue_en) begin
            if (fifo_full_c && !pop_c) err_set_c = 1'b1;
            else                       push_c    = 1'b1;
          end
          if (push_c && (CNT_W'(issued_q + CNT_W'(1)) == count_q)) state_nx = S_DRAIN;
        end else begin
          if (issue_en) err_set_c = 1'b1;
          if (!poly_valid && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
            abort_c   = 1'b1;
            err_set_c = 1'b1;
            state_nx  = S_IDLE;
          end
        end
        if (pop_c && (CNT_W'(retired_q + CNT_W'(1)) == count_q)) begin
          done_c   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Batch bookkeeping: latched config, counters, FIFO pointers, status flags
  always_ff @(posedge poly_clk or negedge poly_rst_n) begin
    if (!poly_rst_n) begin
      count_q   <= '0;
      mask_q    <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      tmo_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (start_c) begin
        count_q   <= (wb_count == '0) ? CNT_W'(256) : wb_count;
        mask_q    <= wb_we_mask;
        issued_q  <= '0;
        retired_q <= '0;
      end else begin
        if (push_c) issued_q  <= issued_q + CNT_W'(1);
        if (pop_c)  retired_q <= retired_q + CNT_W'(1);
      end
      if ((state_q != S_DRAIN) || poly_valid) tmo_q <= '0;
      else                                    tmo_q <= tmo_q + TMO_W'(1);
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (start_c || abort_c) rd_ptr_q <= wr_ptr_q;
      else if (pop_c)         rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (start_c)        err_q <= 1'b0;
      else if (err_set_c) err_q <= 1'b1;
      busy_q <= (state_nx != S_IDLE);
    end
  end

  // Address-pair storage; contents are don't-care until pushed
  always_ff @(posedge poly_clk) begin
    if (push_c) fifo_mem[wr_ptr_q[IDX_W-1:0]] <= {issue_addr1, issue_addr0};
  end

  // Write-back stage: one cycle after a retire, addr/data hold when idle
  always_ff @(posedge poly_clk or negedge poly_rst_n) begin
    if (!poly_rst_n) begin
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      done_q   <= 1'b0;
    end else begin
      we0_q  <= pop_c && mask_q[0];
      we1_q  <= pop_c && mask_q[1];
      done_q <= done_c;
      if (pop_c && mask_q[0]) begin
        addr0_q  <= head_c[ADDR_W-1:0];
        wdata0_q <= poly_data_out0;
      end
      if (pop_c && mask_q[1]) begin
        addr1_q  <= head_c[2*ADDR_W-1:ADDR_W];
        wdata1_q <= poly_data_out1;
      end
    end
  end

`ifdef POLY_WB_REG_OUT_EN
  logic              we0_r, we1_r, done_r;
  logic [ADDR_W-1:0] addr0_r, addr1_r;
  logic [DATA_W-1:0] wdata0_r, wdata1_r;

  // Extra output stage for timing; done follows to stay aligned with we
  always_ff @(posedge poly_clk or negedge poly_rst_n) begin
    if (!poly_rst_n) begin
      we0_r    <= 1'b0;
      we1_r    <= 1'b0;
      addr0_r  <= '0;
      addr1_r  <= '0;
      wdata0_r <= '0;
      wdata1_r <= '0;
      done_r   <= 1'b0;
    end else begin
      we0_r    <= we0_q;
      we1_r    <= we1_q;
      addr0_r  <= addr0_q;
      addr1_r  <= addr1_q;
      wdata0_r <= wdata0_q;
      wdata1_r <= wdata1_q;
      done_r   <= done_q;
    end
  end

  assign ram_we0    = we0_r;
  assign ram_we1    = we1_r;
  assign ram_addr0  = addr0_r;
  assign ram_addr1  = addr1_r;
  assign ram_wdata0 = wdata0_r;
  assign ram_wdata1 = wdata1_r;
  assign wb_done    = done_r;
`else
  assign ram_we0    = we0_q;
  assign ram_we1    = we1_q;
  assign ram_addr0  = addr0_q;
  assign ram_addr1  = addr1_q;
  assign ram_wdata0 = wdata0_q;
  assign ram_wdata1 = wdata1_q;
  assign wb_done    = done_q;
`endif

  assign wb_busy = busy_q;
  assign wb_err  = err_q;

endmodule

// File: tb/tb_poly_wb_ctrl.sv
// Self-checking bench for poly_wb_ctrl: a transaction-level model (address
// queue plus batch counters) predicts every output each cycle; directed tests
// add literal expectations on write counts, addresses, data and timeout length.
module tb_poly_wb_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned TMO   = 64;

  logic          poly_clk, poly_rst_n;
  logic          wb_start, issue_en, poly_valid;
  logic [8:0]    wb_count;
  logic [1:0]    wb_we_mask;
  logic [AW-1:0] issue_addr0, issue_addr1;
  logic [23:0]   poly_data_out0, poly_data_out1;
  logic          ram_we0, ram_we1, wb_busy, wb_done, wb_err;
  logic [AW-1:0] ram_addr0, ram_addr1;
  logic [23:0]   ram_wdata0, ram_wdata1;

  poly_wb_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .poly_clk(poly_clk), .poly_rst_n(poly_rst_n), .wb_start(wb_start),
    .wb_count(wb_count), .wb_we_mask(wb_we_mask), .issue_en(issue_en),
    .issue_addr0(issue_addr0), .issue_addr1(issue_addr1), .poly_valid(poly_valid),
    .poly_data_out0(poly_data_out0), .poly_data_out1(poly_data_out1),
    .ram_we0(ram_we0), .ram_addr0(ram_addr0), .ram_wdata0(ram_wdata0),
    .ram_we1(ram_we1), .ram_addr1(ram_addr1), .ram_wdata1(ram_wdata1),
    .wb_busy(wb_busy), .wb_done(wb_done), .wb_err(wb_err)
  );

  initial poly_clk = 1'b0;
  always #5 poly_clk = ~poly_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic               m_busy, m_drain, m_err, popped;
  int                 m_count, m_issued, m_retired, m_idle;
  logic [1:0]         m_mask;
  logic [2*AW-1:0]    m_q[$];
  logic [2*AW-1:0]    head;
  logic               w_we0, w_we1, w_done, e_we0, e_we1, e_done, e_busy, e_err;
  logic [AW-1:0]      w_a0, w_a1, e_a0, e_a1;
  logic [23:0]        w_d0, w_d1, e_d0, e_d1;

  always @(posedge poly_clk or negedge poly_rst_n) begin
    if (!poly_rst_n) begin
      m_busy = 0; m_drain = 0; m_err = 0; m_count = 0; m_issued = 0; m_retired = 0;
      m_idle = 0; m_mask = 0; m_q.delete();
      w_we0 = 0; w_we1 = 0; w_done = 0; w_a0 = 0; w_a1 = 0; w_d0 = 0; w_d1 = 0;
      e_we0 = 0; e_we1 = 0; e_done = 0; e_a0 = 0; e_a1 = 0; e_d0 = 0; e_d1 = 0;
      e_busy = 0; e_err = 0;
    end else begin
`ifdef POLY_WB_REG_OUT_EN
      e_we0 = w_we0; e_we1 = w_we1; e_a0 = w_a0; e_a1 = w_a1;
      e_d0 = w_d0; e_d1 = w_d1; e_done = w_done;
`endif
      w_we0 = 0; w_we1 = 0; w_done = 0; popped = 0;
      if (!m_busy) begin
        if (wb_start) begin
          m_busy = 1; m_drain = 0; m_err = 0; m_idle = 0;
          m_count = (wb_count == 0) ? 256 : int'(wb_count);
          m_mask = wb_we_mask; m_issued = 0; m_retired = 0; m_q.delete();
        end
      end else begin
        if (poly_valid) begin
          if (m_q.size() == 0) m_err = 1;
          else begin
            popped = 1; head = m_q.pop_front(); m_retired++;
            if (m_mask[0]) begin w_we0 = 1; w_a0 = head[AW-1:0];    w_d0 = poly_data_out0; end
            if (m_mask[1]) begin w_we1 = 1; w_a1 = head[2*AW-1:AW]; w_d1 = poly_data_out1; end
          end
        end
        if (!m_drain) begin
          if (issue_en) begin
            if (m_q.size() < DEPTH) begin
              m_q.push_back({issue_addr1, issue_addr0});
              m_issued++;
              if (m_issued == m_count) m_drain = 1;
            end else m_err = 1;
          end
        end else begin
          if (issue_en) m_err = 1;
          m_idle = poly_valid ? 0 : m_idle + 1;
          if (m_idle == TMO) begin m_err = 1; m_busy = 0; m_q.delete(); end
        end
        if (popped && m_retired == m_count) begin w_done = 1; m_busy = 0; end
      end
`ifndef POLY_WB_REG_OUT_EN
      e_we0 = w_we0; e_we1 = w_we1; e_a0 = w_a0; e_a1 = w_a1;
      e_d0 = w_d0; e_d1 = w_d1; e_done = w_done;
`endif
      e_busy = m_busy; e_err = m_err;
    end
  end

  // ---------------- per-cycle compare and write monitor ----------------
  int            cnt_we0, cnt_we1, cnt_done;
  logic [AW-1:0] lg_a0[$], lg_a1[$];
  logic [23:0]   lg_d0[$], lg_d1[$];

  always @(negedge poly_clk) begin
    if (chk_en) begin
      chk("ram_we0",    32'(ram_we0),    32'(e_we0));
      chk("ram_we1",    32'(ram_we1),    32'(e_we1));
      chk("ram_addr0",  32'(ram_addr0),  32'(e_a0));
      chk("ram_addr1",  32'(ram_addr1),  32'(e_a1));
      chk("ram_wdata0", 32'(ram_wdata0), 32'(e_d0));
      chk("ram_wdata1", 32'(ram_wdata1), 32'(e_d1));
      chk("wb_busy",    32'(wb_busy),    32'(e_busy));
      chk("wb_done",    32'(wb_done),    32'(e_done));
      chk("wb_err",     32'(wb_err),     32'(e_err));
      if (ram_we0 === 1'b1) begin cnt_we0++; lg_a0.push_back(ram_addr0); lg_d0.push_back(ram_wdata0); end
      if (ram_we1 === 1'b1) begin cnt_we1++; lg_a1.push_back(ram_addr1); lg_d1.push_back(ram_wdata1); end
      if (wb_done === 1'b1) cnt_done++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge poly_clk); #1;
  endtask

  task automatic idle_in();
    wb_start = 0; wb_count = 0; wb_we_mask = 0; issue_en = 0;
    issue_addr0 = 0; issue_addr1 = 0; poly_valid = 0;
    poly_data_out0 = 0; poly_data_out1 = 0;
  endtask

  task automatic clr_stats();
    cnt_we0 = 0; cnt_we1 = 0; cnt_done = 0;
    lg_a0.delete(); lg_a1.delete(); lg_d0.delete(); lg_d1.delete();
  endtask

  task automatic start_batch(input logic [8:0] cnt, input logic [1:0] mask);
    wb_start = 1; wb_count = cnt; wb_we_mask = mask;
    cyc();
    wb_start = 0;
  endtask

  task automatic reset_pulse();
    poly_rst_n = 0; #2; poly_rst_n = 1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    idle_in();
    clr_stats();
    poly_rst_n = 0;
    cyc(); cyc();
    chk_en = 1;
    // reset state
    chk("rst_busy",  32'(wb_busy),   32'd0);
    chk("rst_we0",   32'(ram_we0),   32'd0);
    chk("rst_addr1", 32'(ram_addr1), 32'd0);
    chk("rst_err",   32'(wb_err),    32'd0);
    poly_rst_n = 1;
    cyc();

    // basic batch, with an ignored wb_start while busy
    clr_stats();
    start_batch(9'd4, 2'b11);
    for (int c = 0; c < 12; c++) begin
      issue_en = (c < 4); issue_addr0 = AW'(c); issue_addr1 = AW'(128 + c);
      poly_valid = (c >= 5 && c < 9);
      poly_data_out0 = 24'(11 + c); poly_data_out1 = 24'(27 + c);
      wb_start = (c == 2); wb_count = (c == 2) ? 9'd1 : 9'd4;
      cyc();
    end
    idle_in(); cyc(); cyc();
    chk("basic_we0_cnt", 32'(cnt_we0), 32'd4);
    chk("basic_we1_cnt", 32'(cnt_we1), 32'd4);
    chk("basic_done_cnt", 32'(cnt_done), 32'd1);
    chk("basic_err", 32'(wb_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < lg_a0.size() && i < lg_a1.size()) begin
        chk("basic_a0", 32'(lg_a0[i]), 32'(i));
        chk("basic_a1", 32'(lg_a1[i]), 32'(128 + i));
        chk("basic_d0", 32'(lg_d0[i]), 32'(24'h10 + 24'(i)));
        chk("basic_d1", 32'(lg_d1[i]), 32'(24'h20 + 24'(i)));
      end
    end

    // port mask
    clr_stats();
    start_batch(9'd2, 2'b01);
    for (int c = 0; c < 8; c++) begin
      issue_en = (c < 2); issue_addr0 = AW'(10 + c); issue_addr1 = AW'(20 + c);
      poly_valid = (c == 4 || c == 5); poly_data_out0 = 24'(c); poly_data_out1 = 24'(100 + c);
      cyc();
    end
    idle_in(); cyc();
    chk("mask_we0_cnt", 32'(cnt_we0), 32'd2);
    chk("mask_we1_cnt", 32'(cnt_we1), 32'd0);
    chk("mask_done_cnt", 32'(cnt_done), 32'd1);

    // FIFO full: 9 issues, 9th dropped; then full push+pop, then drain 8
    clr_stats();
    start_batch(9'd16, 2'b11);
    for (int c = 0; c < 9; c++) begin
      issue_en = 1; issue_addr0 = AW'(c); issue_addr1 = AW'(64 + c);
      cyc();
    end
    idle_in(); cyc();
    chk("full_err", 32'(wb_err), 32'd1);
    chk("full_busy", 32'(wb_busy), 32'd1);
    chk("full_model_issued", 32'(m_issued), 32'd8);
    chk("full_model_occ", 32'(m_q.size()), 32'd8);
    issue_en = 1; issue_addr0 = 8'd50; issue_addr1 = 8'd51;
    poly_valid = 1; poly_data_out0 = 24'hABC; poly_data_out1 = 24'hDEF;
    cyc();
    idle_in(); cyc();
    chk("full_pp_occ", 32'(m_q.size()), 32'd8);
    chk("full_pp_issued", 32'(m_issued), 32'd9);
    for (int c = 0; c < 8; c++) begin
      poly_valid = 1; poly_data_out0 = 24'(c); poly_data_out1 = 24'(c);
      cyc();
    end
    idle_in(); cyc(); cyc();
    chk("full_we0_cnt", 32'(cnt_we0), 32'd9);
    chk("full_busy_after", 32'(wb_busy), 32'd1);
    if (lg_a0.size() == 9) chk("full_last_a0", 32'(lg_a0[8]), 32'd50);
    else chk("full_log_len", 32'(lg_a0.size()), 32'd9);
    reset_pulse();

    // spurious valid on empty FIFO, and push+valid into empty FIFO
    clr_stats();
    start_batch(9'd2, 2'b11);
    poly_valid = 1; cyc();
    issue_en = 1; issue_addr0 = 8'd7; issue_addr1 = 8'd8; cyc();
    idle_in(); cyc();
    chk("spur_we_cnt", 32'(cnt_we0), 32'd0);
    chk("spur_err", 32'(wb_err), 32'd1);
    poly_valid = 1; poly_data_out0 = 24'h55; cyc();
    idle_in(); cyc(); cyc();
    chk("spur_we0_cnt", 32'(cnt_we0), 32'd1);
    chk("spur_model_retired", 32'(m_retired), 32'd1);
    chk("spur_busy", 32'(wb_busy), 32'd1);
    reset_pulse();

    // DRAIN timeout: 3 issues, 2 valids
    clr_stats();
    start_batch(9'd3, 2'b11);
    for (int c = 0; c < 5; c++) begin
      issue_en = (c < 3); issue_addr0 = AW'(30 + c); issue_addr1 = AW'(40 + c);
      poly_valid = (c >= 3);
      cyc();
    end
    idle_in();
    n = 0;
    while (n < 200) begin
      @(negedge poly_clk);
      if (!wb_busy) break;
      n++;
    end
    chk("tmo_len", 32'(n), 32'd64);
    cyc();
    chk("tmo_busy", 32'(wb_busy), 32'd0);
    chk("tmo_err", 32'(wb_err), 32'd1);
    chk("tmo_done_cnt", 32'(cnt_done), 32'd0);
    chk("tmo_we0_cnt", 32'(cnt_we0), 32'd2);

    // reset in DRAIN with 3 pending entries
    clr_stats();
    start_batch(9'd4, 2'b11);
    for (int c = 0; c < 8; c++) begin
      issue_en = (c < 4); issue_addr0 = AW'(c + 1); issue_addr1 = AW'(c + 2);
      poly_valid = (c == 4); poly_data_out0 = 24'h77; poly_data_out1 = 24'h88;
      cyc();
    end
    idle_in();
    chk("pre_rst_busy", 32'(wb_busy), 32'd1);
    poly_rst_n = 0; #1;
    chk("mid_rst_busy",   32'(wb_busy),    32'd0);
    chk("mid_rst_addr0",  32'(ram_addr0),  32'd0);
    chk("mid_rst_wdata1", 32'(ram_wdata1), 32'd0);
    #1 poly_rst_n = 1;
    cyc();
    clr_stats();
    for (int c = 0; c < 3; c++) begin poly_valid = 1; cyc(); end
    idle_in(); cyc(); cyc(); cyc();
    chk("post_rst_we_cnt", 32'(cnt_we0 + cnt_we1), 32'd0);

    // wb_count = 0 means 256 operations
    clr_stats();
    start_batch(9'd0, 2'b10);
    for (int c = 0; c < 262; c++) begin
      issue_en = (c < 256); issue_addr0 = AW'(c); issue_addr1 = AW'(255 - c);
      poly_valid = (c >= 3 && c < 259); poly_data_out0 = 24'(c); poly_data_out1 = 24'(c);
      cyc();
    end
    idle_in(); cyc();
    chk("c256_we1_cnt", 32'(cnt_we1), 32'd256);
    chk("c256_we0_cnt", 32'(cnt_we0), 32'd0);
    chk("c256_done_cnt", 32'(cnt_done), 32'd1);
    chk("c256_busy", 32'(wb_busy), 32'd0);
    chk("c256_err", 32'(wb_err), 32'd0);
    if (lg_a1.size() == 256) begin
      chk("c256_last_a1", 32'(lg_a1[255]), 32'd0);
      chk("c256_first_d1", 32'(lg_d1[0]), 32'd3);
    end else chk("c256_log_len", 32'(lg_a1.size()), 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
